// File: rtl/mmio_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// mmio_pkg : address map and shared types for the mmio_spart peripheral
// Rev 1.0
// ---------------------------------------------------------------------------
package mmio_pkg;

  localparam logic [15:0] ADDR_SW   = 16'hC001;
  localparam logic [15:0] ADDR_DATA = 16'hC004;
  localparam logic [15:0] ADDR_STAT = 16'hC005;
  localparam logic [15:0] ADDR_DIV  = 16'hC006;
  localparam logic [15:0] DEAD_DATA = 16'hDEAD;
  localparam logic [15:0] MIN_DIV   = 16'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Below 4 clocks per bit the half-bit start check collapses.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// mmio_fifo : synchronous FIFO with combinational head (no read latency)
// Rev 1.0
// ---------------------------------------------------------------------------
module mmio_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // When full, a simultaneous pop frees the slot the push lands in.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mmio_spart.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// mmio_spart : memory-mapped 8N1 UART (TX/RX FIFOs) plus switch input port
// Rev 1.0
// ---------------------------------------------------------------------------
module mmio_spart
  import mmio_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  input  logic [9:0]  sw,
  input  logic        rx,
  output logic        tx
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0] div_q, div_d;
  logic        ovr_q, ovr_d;

  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_head;
  logic [CW-1:0] tx_count, tx_free;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_head;
  logic [CW-1:0] rx_count;

  uart_state_e tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d, tx_load;

  uart_state_e rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_s1_q, rx_s2_q;

  assign tx      = tx_q;
  assign tx_free = CW'(FIFO_DEPTH) - tx_count;
  assign tx_push = we && (addr == ADDR_DATA) && (!tx_full || tx_pop);
  assign rx_pop  = re && (addr == ADDR_DATA) && !rx_empty;

  mmio_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(tx_push), .pop_i(tx_pop), .data_i(wdata[7:0]),
    .data_o(tx_head), .count_o(tx_count), .full_o(tx_full), .empty_o(tx_empty)
  );

  mmio_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(rx_push), .pop_i(rx_pop), .data_i(rx_shift_q),
    .data_o(rx_head), .count_o(rx_count), .full_o(rx_full), .empty_o(rx_empty)
  );

  always_comb begin
    case (addr)
      ADDR_SW:   rdata = {6'b0, sw};
      ADDR_DATA: rdata = rx_empty ? 16'h0000 : {8'h00, rx_head};
      ADDR_STAT: rdata = {7'b0, ovr_q, 4'(rx_count), 4'(tx_free)};
      ADDR_DIV:  rdata = div_q;
      default:   rdata = DEAD_DATA;
    endcase
  end

  always_comb begin
    div_d = div_q;
    if (we && (addr == ADDR_DIV)) div_d = clamp_div(wdata);
    ovr_d = ovr_q;
    if (we && (addr == ADDR_STAT)) ovr_d = 1'b0;
    if (rx_push && rx_full && !rx_pop) ovr_d = 1'b1;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_load    = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        tx_cnt_d = '0;
        tx_load  = !tx_empty;
      end
      ST_START: if (tx_cnt_q == tx_div_q - 16'd1) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_d       = tx_shift_q[0];
        tx_shift_d = tx_shift_q >> 1;
        tx_state_d = ST_DATA;
      end
      ST_DATA: if (tx_cnt_q == tx_div_q - 16'd1) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_d       = 1'b1;
          tx_state_d = ST_STOP;
        end else begin
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 3'd1;
        end
      end
      ST_STOP: if (tx_cnt_q == tx_div_q - 16'd1) begin
        tx_state_d = ST_IDLE;
        tx_load    = !tx_empty;
      end
      default: tx_state_d = ST_IDLE;
    endcase
    // Loading from STOP chains frames with no idle gap.
    if (tx_load) begin
      tx_shift_d = tx_head;
      tx_div_d   = div_q;
      tx_cnt_d   = '0;
      tx_d       = 1'b0;
      tx_state_d = ST_START;
    end
  end
  assign tx_pop = tx_load;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s2_q) begin
          rx_div_d   = div_q;
          rx_state_d = ST_START;
        end
      end
      ST_START: if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (rx_cnt_q == rx_div_q - 16'd1) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
      end
      ST_STOP: if (rx_cnt_q == rx_div_q - 16'd1) begin
        rx_push    = rx_s2_q;
        rx_state_d = ST_IDLE;
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q      <= DEFAULT_DIV;
      ovr_q      <= 1'b0;
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DEFAULT_DIV;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DEFAULT_DIV;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
    end else begin
      div_q      <= div_d;
      ovr_q      <= ovr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_spart.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mmio_spart : scoreboard bench for the mmio_spart UART/switch peripheral
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mmio_spart;
  localparam int DIV = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic [9:0]  sw = 10'h000;
  logic        rx;
  logic        tx;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  assign rx = loop_en ? tx : rx_drv;

  mmio_spart #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd434)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .re(re), .we(we), .wdata(wdata),
    .rdata(rdata), .sw(sw), .rx(rx), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Decodes every frame seen on tx and retires it against the TX scoreboard.
  initial begin : p_tx_mon
    logic [7:0] b;
    logic [7:0] e;
    logic       stp;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        stp = tx;
        n_vec++;
        if (tx_exp.size() == 0) begin
          n_err++;
          $display("FAIL tx_frame: got byte %h with no byte expected", b);
        end else begin
          e = tx_exp.pop_front();
          if (b !== e || stp !== 1'b1) begin
            n_err++;
            $display("FAIL tx_frame: got byte %h stop %b, expected byte %h stop 1", b, stp, e);
          end
        end
      end
    end
  end

  initial begin : p_watchdog
    #1_000_000;
    $display("FAIL watchdog: got no finish by %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0; addr = 16'h0000;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a; re = 1'b1;
    #1 d = rdata;
    @(negedge clk);
    re = 1'b0; addr = 16'h0000;
  endtask

  task automatic send_rx(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_drv = fr[i];
      repeat (DIV - 1) @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] d;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_vec++;
    if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b expected 1", tx); end
    bus_read(16'hC005, d);
    n_vec++;
    if (d !== 16'h0008) begin n_err++; $display("FAIL reset_status: got %h expected 0008", d); end
    bus_read(16'hC006, d);
    n_vec++;
    if (d !== 16'd434) begin n_err++; $display("FAIL reset_div: got %h expected %h", d, 16'd434); end
    bus_read(16'hC010, d);
    n_vec++;
    if (d !== 16'hDEAD) begin n_err++; $display("FAIL unmapped_read: got %h expected DEAD", d); end
  endtask

  task automatic test_switches();
    logic [15:0] d;
    sw = 10'h3FF;
    bus_read(16'hC001, d);
    n_vec++;
    if (d !== 16'h03FF) begin n_err++; $display("FAIL sw_all: got %h expected 03FF", d); end
    sw = 10'h155;
    bus_read(16'hC001, d);
    n_vec++;
    if (d !== 16'h0155) begin n_err++; $display("FAIL sw_alt: got %h expected 0155", d); end
  endtask

  task automatic test_divisor();
    logic [15:0] d;
    bus_write(16'hC006, 16'd2);
    bus_read(16'hC006, d);
    n_vec++;
    if (d !== 16'd4) begin n_err++; $display("FAIL div_clamp: got %h expected 0004", d); end
    bus_write(16'hC006, 16'd16);
    bus_read(16'hC006, d);
    n_vec++;
    if (d !== 16'd16) begin n_err++; $display("FAIL div_write: got %h expected 0010", d); end
  endtask

  task automatic test_tx_frame();
    logic [9:0] fr;
    int bad;
    fr = {1'b1, 8'hA5, 1'b0};
    loop_en = 1'b1;
    tx_exp.push_back(8'hA5);
    @(negedge clk);
    addr = 16'hC004; wdata = 16'h00A5; we = 1'b1;
    @(negedge clk);
    we = 1'b0; addr = 16'h0000;
    n_vec++;
    if (tx !== 1'b1) begin n_err++; $display("FAIL tx_latency: got %b at commit edge expected 1", tx); end
    for (int i = 0; i < 10; i++) begin
      bad = 0;
      repeat (DIV) begin
        @(negedge clk);
        if (tx !== fr[i]) bad++;
      end
      n_vec++;
      if (bad != 0) begin n_err++; $display("FAIL tx_bit%0d: got %0d wrong cycles expected level %b", i, bad, fr[i]); end
    end
    @(negedge clk);
    n_vec++;
    if (tx !== 1'b1) begin n_err++; $display("FAIL tx_idle: got %b expected 1", tx); end
  endtask

  task automatic test_loopback();
    logic [15:0] d;
    bus_read(16'hC005, d);
    n_vec++;
    if (d !== 16'h0018) begin n_err++; $display("FAIL loop_status: got %h expected 0018", d); end
    bus_read(16'hC004, d);
    n_vec++;
    if (d !== 16'h00A5) begin n_err++; $display("FAIL loop_data: got %h expected 00A5", d); end
    bus_read(16'hC005, d);
    n_vec++;
    if (d !== 16'h0008) begin n_err++; $display("FAIL loop_popped: got %h expected 0008", d); end
    bus_read(16'hC004, d);
    n_vec++;
    if (d !== 16'h0000) begin n_err++; $display("FAIL loop_empty: got %h expected 0000", d); end
    loop_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    logic [7:0]  b;
    int c0, o, bad_idle;
    int bad[9];
    foreach (bad[k]) bad[k] = 0;
    bad_idle = 0;
    @(negedge clk);
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      b = 8'(8'h30 + i);
      addr = 16'hC004; wdata = {8'h00, b}; we = 1'b1;
      if (i < 9) tx_exp.push_back(b);
      @(negedge clk);
    end
    we = 1'b0; addr = 16'h0000;
    bus_read(16'hC005, d);
    n_vec++;
    if (d !== 16'h0000) begin n_err++; $display("FAIL b2b_full_status: got %h expected 0000", d); end
    while (cyc - (c0 + 2) < 9 * 160 + 32) begin
      @(negedge clk);
      o = cyc - (c0 + 2);
      if (o < 9 * 160) begin
        if ((o % 160) < 16 && tx !== 1'b0) bad[o / 160]++;
        if ((o % 160) >= 144 && tx !== 1'b1) bad[o / 160]++;
      end else if (tx !== 1'b1) bad_idle++;
    end
    for (int k = 0; k < 9; k++) begin
      n_vec++;
      if (bad[k] != 0) begin n_err++; $display("FAIL b2b_frame%0d_framing: got %0d wrong cycles expected 0", k, bad[k]); end
    end
    n_vec++;
    if (bad_idle != 0) begin n_err++; $display("FAIL b2b_idle: got %0d busy cycles after 9 frames expected 0", bad_idle); end
    n_vec++;
    if (tx_exp.size() != 0) begin n_err++; $display("FAIL tx_scoreboard: got %0d frames missing expected 0", tx_exp.size()); end
    bus_read(16'hC005, d);
    n_vec++;
    if (d !== 16'h0008) begin n_err++; $display("FAIL b2b_drained: got %h expected 0008", d); end
  endtask

  task automatic test_rx_overrun();
    logic [15:0] d;
    logic [7:0]  e;
    for (int i = 1; i <= 9; i++) begin
      send_rx(8'(i));
      if (i <= 8) rx_exp.push_back(8'(i));
    end
    bus_read(16'hC005, d);
    n_vec++;
    if (d !== 16'h0188) begin n_err++; $display("FAIL ovr_status: got %h expected 0188", d); end
    bus_write(16'hC005, 16'h1234);
    bus_read(16'hC005, d);
    n_vec++;
    if (d !== 16'h0088) begin n_err++; $display("FAIL ovr_clear: got %h expected 0088", d); end
    while (rx_exp.size() != 0) begin
      e = rx_exp.pop_front();
      bus_read(16'hC004, d);
      n_vec++;
      if (d !== {8'h00, e}) begin n_err++; $display("FAIL rx_data: got %h expected %h", d, {8'h00, e}); end
    end
    bus_read(16'hC004, d);
    n_vec++;
    if (d !== 16'h0000) begin n_err++; $display("FAIL rx_drained: got %h expected 0000", d); end
  endtask

  task automatic test_false_start();
    logic [15:0] d;
    logic [7:0]  e;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (12) @(negedge clk);
    bus_read(16'hC005, d);
    n_vec++;
    if (d !== 16'h0008) begin n_err++; $display("FAIL false_start_status: got %h expected 0008", d); end
    send_rx(8'h5A);
    rx_exp.push_back(8'h5A);
    bus_read(16'hC005, d);
    n_vec++;
    if (d !== 16'h0018) begin n_err++; $display("FAIL after_glitch_status: got %h expected 0018", d); end
    e = rx_exp.pop_front();
    bus_read(16'hC004, d);
    n_vec++;
    if (d !== {8'h00, e}) begin n_err++; $display("FAIL after_glitch_data: got %h expected %h", d, {8'h00, e}); end
  endtask

  initial begin
    test_reset();
    test_switches();
    test_divisor();
    test_tx_frame();
    test_loopback();
    test_back_to_back();
    test_rx_overrun();
    test_false_start();
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmio_spart.md
# mmio_spart

Memory-mapped serial port and switch-input peripheral on the CPU's external data bus (addresses ≥ 0x2000). It decodes the CPU's `addr`/`re`/`we`/`wdata` and drives `rdata` for the CPU's EX_DM-stage read mux. It contains 8N1 UART transmit and receive engines, each with its own FIFO.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: entries per TX and RX FIFO; must be a power of 2.
- `DEFAULT_DIV`, 16'd434: reset value of the baud divisor, in clocks per bit.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `addr` in 16: CPU data address.
- `re` in 1: read strobe.
- `we` in 1: write strobe.
- `wdata` in 16: CPU store data.
- `rdata` out 16: read data, combinational from `addr` and state.
- `sw` in 10: board switches.
- `rx` in 1: serial in, asynchronous.
- `tx` out 1: serial out, registered.

## Operation
Address map (full 16-bit compare):
- 0xC001, read: `{6'b0, sw}`.
- 0xC004, write: push `wdata[7:0]` to the TX FIFO; silently dropped if the TX FIFO is full.
- 0xC004, read: `{8'h00, RX head}` and pop. If the RX FIFO is empty, returns 16'h0000 and does not pop.
- 0xC005, read: status. `[3:0]` = TX free entries, `[7:4]` = RX occupied entries, `[8]` = sticky RX overrun, other bits 0.
- 0xC005, write (any data): clears the overrun bit.
- 0xC006, read/write: baud divisor. Written values below 4 are stored as 4.
- Any other address: reads return 16'hDEAD; writes are ignored.

Bus contract:
- The CPU asserts `re`/`we` for exactly one cycle per access.
- A pop or push occurs on the edge that ends that cycle.

TX FSM: IDLE → START → DATA → STOP → IDLE.
- In IDLE with the TX FIFO non-empty: pop, load the shift register, latch the divisor, and drive `tx`=0.
- Each bit lasts DIV cycles. Data is sent LSB first over 8 bits. Stop bit = 1.
- From STOP, the FSM returns to IDLE, or goes directly to START if the FIFO is non-empty, with no idle gap.

RX path:
- `rx` passes through a 2-flop synchronizer.
- IDLE: a synced low moves the FSM to START, and the divisor is latched.
- START: wait DIV/2 cycles, then resample. If the sample is high, it is a false start; return to IDLE.
- DATA: 8 samples, one every DIV cycles, assembled LSB first.
- STOP: after DIV cycles, sample.
  - 1: push the byte. If the RX FIFO is full, drop the byte and set overrun.
  - 0: framing error; discard the byte.
  - Either outcome returns the FSM to IDLE.

A divisor write mid-frame takes effect at the next frame start for each engine.

## Timing
Reset values:
- `tx`=1.
- Both FIFOs empty; overrun=0.
- Divisor = `DEFAULT_DIV`.
- Both FSMs in IDLE; synchronizer flops = 1.
- `rdata` follows `addr`: 16'hDEAD for unmapped addresses, status reads 0x0008 when `FIFO_DEPTH`=8.

Latency and edge rules:
- A TX write committed at edge N: `tx` falls at edge N+1 if the TX FSM is in IDLE.
- A full frame is 10·DIV cycles.
- An RX byte becomes visible in status 1 cycle after the mid-stop-bit sample.
- Status reads reflect pre-edge values; a push or pop in the same cycle is not yet counted.

Simultaneous events:
- Full RX FIFO with a CPU pop and an RX push in the same cycle: both happen, count is unchanged, no overrun.
- Full TX FIFO with a CPU push and a TX pop in the same cycle: the push is accepted.
- Overrun set and a 0xC005 write in the same cycle: the set wins.

Reset asserted mid-frame:
- Both frames are abandoned, `tx` returns to 1 on the next edge, and the FIFOs clear.

## Structure
- `mmio_pkg` contains:
  - Address constants: 0xC001, 0xC004, 0xC005, 0xC006.
  - `DEAD_DATA` = 16'hDEAD.
  - Minimum divisor = 4.
  - Shared UART state enum {IDLE, START, DATA, STOP}.
- Sub-module `mmio_fifo` is a synchronous FIFO with push, pop, data, count, full, and empty. It is instantiated twice, once for TX and once for RX.
- Each pop has data at the head combinationally, with no read latency, because `rdata` is combinational.

## Test plan
1. Reset, then read 0xC005 → 16'h0008. Read 0xC006 → `DEFAULT_DIV`. `tx` is 1. Read 0xC010 → 16'hDEAD.
2. Set `sw`=10'h3FF and read 0xC001 → 16'h03FF.
3. Write 0xC006=16, then write 0xC004=16'h00A5 → `tx` goes low the next cycle for 16 cycles. Then bits 1,0,1,0,0,1,0,1 follow at 16 cycles each, then high for 16 cycles. The frame is 160 cycles total.
4. Loop back `tx`→`rx` after step 3 → 0xC005[7:4]=1. Reading 0xC004 returns 16'h00A5, after which 0xC005[7:4]=0. A further read of 0xC004 returns 16'h0000.
5. Write 10 bytes to 0xC004 on consecutive cycles (DIV=16) → status [3:0]=0 afterwards. The 10th byte is dropped, and exactly 9 frames are sent back-to-back.
6. Inject 9 RX frames (DIV=16) with no reads → [8]=1 and [7:4]=8. Write 0xC005 → [8]=0. Eight reads return bytes 1–8 in order.
7. Drive `rx` low for 3 cycles at DIV=16 → no byte is received and the RX FSM is back in IDLE by cycle 12.
